// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use bubble, taken-branch flush and multi-cycle mult/div hold for a 5-stage pipeline.
// The mult/div hold FSM is built only when HAZARD_MULDIV_STALL_EN is defined.
module hazard_ctrl #(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        muldiv_start,
    input  logic        branch_taken,
    input  logic        perf_clr,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_stall,
    output logic        ifid_flush,
    output logic        ex_hold,
    output logic        muldiv_done,
    output logic [1:0]  busy_state,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        MD_BUSY = 2'b01
    } state_t;

    logic        load_use_s;
    logic [15:0] stall_count_r;

    // $zero is never a real load destination, so it cannot create a hazard
    assign load_use_s = ex_memread && (ex_rt != 5'd0) &&
                        ((id_uses_rs && (id_rs == ex_rt)) ||
                         (id_uses_rt && (id_rt == ex_rt)));

`ifdef HAZARD_MULDIV_STALL_EN

    localparam int               CW       = $clog2(MULDIV_CYCLES);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(MULDIV_CYCLES - 2);

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;

    // FSM state and mult/div countdown register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next state and hazard controls; outputs held at pass-through while in reset
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_stall  = 1'b0;
        ifid_flush  = 1'b0;
        ex_hold     = 1'b0;
        muldiv_done = 1'b0;
        if (!rst_n) begin
            state_s = IDLE;
            cnt_s   = {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (muldiv_start) begin
                        state_s    = MD_BUSY;
                        cnt_s      = CNT_LOAD;
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        ex_hold    = 1'b1;
                    end else if (branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_stall = 1'b1;
                    end else if (load_use_s) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_stall = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end
                MD_BUSY: begin
                    // last occupancy cycle releases EX while the result writes back
                    if (cnt_r == {CW{1'b0}}) begin
                        muldiv_done = 1'b1;
                        state_s     = IDLE;
                    end else begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        ex_hold    = 1'b1;
                        cnt_s      = cnt_r - CW'(1'b1);
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = {CW{1'b0}};
                end
            endcase
        end
    end

    assign busy_state = state_r;

`else

    logic unused_muldiv_s;
    assign unused_muldiv_s = muldiv_start;

    // Hazard controls without mult/div support; outputs held at pass-through while in reset
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        idex_stall = 1'b0;
        ifid_flush = 1'b0;
        if (!rst_n) begin
            pc_write = 1'b1;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_stall = 1'b1;
        end else if (load_use_s) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_stall = 1'b1;
        end else begin
            pc_write = 1'b1;
        end
    end

    assign ex_hold     = 1'b0;
    assign muldiv_done = 1'b0;
    assign busy_state  = IDLE;

`endif

    // Saturating count of cycles lost to stalls or flushes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_r <= 16'd0;
        end else if (perf_clr) begin
            stall_count_r <= 16'd0;
        end else if ((!pc_write || ifid_flush) && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall_count = stall_count_r;

endmodule
